// File: rtl/cpc_backplane_pkg.sv
// Shared backplane types: arbiter state encoding, default slot count
// and active-low level constants. No ports (package).
package cpc_backplane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_RELEASE
    } arb_state_e;

    localparam int DEFAULT_NSLOTS = 4;

    localparam logic ASSERT_B = 1'b0;
    localparam logic NEGATE_B = 1'b1;

endpackage

// File: rtl/cpc_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Ports: req[N] active-high requests, ptr start index; valid, idx result.
module cpc_rr_pick
    import cpc_backplane_pkg::*;
#(
    parameter int N = DEFAULT_NSLOTS
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so that bit 0 of rot is the slot at ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/cpc_busrq_arbiter.sv
// Round-robin bus-request arbiter between expansion slots and the Z80.
// Ports: CLK, RESET_B (async low); SLOT_BUSRQ_B in / SLOT_BUSACK_B out
// per slot; BUSRQ_B out / BUSACK_B in to Z80; GRANT_ID, HOLD_ERR status.
module cpc_busrq_arbiter
    import cpc_backplane_pkg::*;
#(
    parameter int NSLOTS      = DEFAULT_NSLOTS,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_LIMIT  = 0,
    parameter int CW          = 16
) (
    input  logic                      CLK,
    input  logic                      RESET_B,
    input  logic [NSLOTS-1:0]         SLOT_BUSRQ_B,
    output logic [NSLOTS-1:0]         SLOT_BUSACK_B,
    output logic                      BUSRQ_B,
    input  logic                      BUSACK_B,
    output logic [$clog2(NSLOTS)-1:0] GRANT_ID,
    output logic                      HOLD_ERR
);

    localparam int IW = $clog2(NSLOTS);
    localparam logic [IW-1:0] LAST_SLOT = IW'(NSLOTS - 1);
    localparam logic [CW-1:0] HOLD_LAST =
        (HOLD_LIMIT == 0) ? '0 : CW'(HOLD_LIMIT - 1);

    logic [SYNC_STAGES-1:0][NSLOTS-1:0] sync_q;
    logic [NSLOTS-1:0] req;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              hold_hit;
    arb_state_e        state_q;

    // Slot requests are asynchronous; shift through SYNC_STAGES flops.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SLOT_BUSRQ_B};
        end
    end

    assign req = ~sync_q[SYNC_STAGES-1];

    cpc_rr_pick #(
        .N(NSLOTS)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // Fires on the last permitted grant cycle, so the ack is low for
    // exactly HOLD_LIMIT cycles.
    assign hold_hit = (HOLD_LIMIT != 0) && (cnt_q == HOLD_LAST);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            BUSRQ_B       <= NEGATE_B;
            SLOT_BUSACK_B <= '1;
            GRANT_ID      <= '0;
            HOLD_ERR      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        GRANT_ID <= pick_idx;
                        BUSRQ_B  <= ASSERT_B;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!req[GRANT_ID]) begin
                        BUSRQ_B <= NEGATE_B;
                        state_q <= ST_RELEASE;
                    end else if (BUSACK_B == ASSERT_B) begin
                        SLOT_BUSACK_B <= ~(NSLOTS'(1) << GRANT_ID);
                        ptr_q <= (GRANT_ID == LAST_SLOT) ?
                                 '0 : GRANT_ID + 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (!req[GRANT_ID] || hold_hit) begin
                        BUSRQ_B       <= NEGATE_B;
                        SLOT_BUSACK_B <= '1;
                        state_q       <= ST_RELEASE;
                        // A voluntary drop on the limit cycle is not an error.
                        if (req[GRANT_ID]) begin
                            HOLD_ERR <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (BUSACK_B == NEGATE_B) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_busrq_arbiter.sv
// Directed self-checking bench for cpc_busrq_arbiter (4 slots, hold limit 8).
// Drives slot requests and a Z80 BUSACK model; checks grants and timing.
module tb_cpc_busrq_arbiter;

    localparam int NS = 4;
    localparam int HL = 8;

    logic          CLK = 1'b0;
    logic          RESET_B = 1'b0;
    logic [NS-1:0] SLOT_BUSRQ_B = '1;
    logic [NS-1:0] SLOT_BUSACK_B;
    logic          BUSRQ_B;
    logic          BUSACK_B;
    logic [1:0]    GRANT_ID;
    logic          HOLD_ERR;

    int n_checks = 0;
    int n_fail = 0;

    logic z80_en = 1'b1;
    logic man_ack_b = 1'b1;
    logic z80_ack_b = 1'b1;
    int   ack_delay = 0;
    int   rq_cnt = 0;
    int   low_run = 0;

    always #5 CLK = ~CLK;

    cpc_busrq_arbiter #(
        .NSLOTS(NS),
        .SYNC_STAGES(2),
        .HOLD_LIMIT(HL),
        .CW(16)
    ) dut (
        .CLK(CLK),
        .RESET_B(RESET_B),
        .SLOT_BUSRQ_B(SLOT_BUSRQ_B),
        .SLOT_BUSACK_B(SLOT_BUSACK_B),
        .BUSRQ_B(BUSRQ_B),
        .BUSACK_B(BUSACK_B),
        .GRANT_ID(GRANT_ID),
        .HOLD_ERR(HOLD_ERR)
    );

    // Z80 model: acknowledges ack_delay cycles after seeing BUSRQ_B low,
    // releases one cycle after BUSRQ_B returns high.
    assign BUSACK_B = z80_en ? z80_ack_b : man_ack_b;

    always @(posedge CLK) begin
        if (BUSRQ_B) begin
            rq_cnt    <= 0;
            z80_ack_b <= 1'b1;
        end else if (rq_cnt >= ack_delay) begin
            z80_ack_b <= 1'b0;
        end else begin
            rq_cnt <= rq_cnt + 1;
        end
    end

    // Invariants checked every cycle throughout all tests.
    always @(negedge CLK) begin
        if (SLOT_BUSACK_B != '1) low_run++;
        else low_run = 0;
        if (RESET_B) begin
            n_checks++;
            if (!$onehot0(~SLOT_BUSACK_B)) begin
                n_fail++;
                $display("FAIL onehot_ack: got %b, need at most one low",
                         SLOT_BUSACK_B);
            end
            n_checks++;
            if (SLOT_BUSACK_B != '1 && BUSRQ_B !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_without_busrq: ack %b busrq %b, need busrq 0",
                         SLOT_BUSACK_B, BUSRQ_B);
            end
            n_checks++;
            if (low_run > HL) begin
                n_fail++;
                $display("FAIL hold_len: ack low %0d cycles, need <= %0d",
                         low_run, HL);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_reset(input logic [NS-1:0] slots);
        RESET_B      = 1'b0;
        SLOT_BUSRQ_B = slots;
        z80_en       = 1'b1;
        man_ack_b    = 1'b1;
        ack_delay    = 0;
        tick(2);
        RESET_B = 1'b1;
    endtask

    // Wait (bounded) for an ack low (want_low=1) or all acks high.
    task automatic wait_ack(input bit want_low, output bit ok,
                            output bit saw_high);
        ok = 1'b0;
        saw_high = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ((SLOT_BUSACK_B != '1) == want_low) begin
                ok = 1'b1;
                break;
            end
            if (BUSACK_B === 1'b1) saw_high = 1'b1;
            tick(1);
        end
    endtask

    task automatic test_reset();
        RESET_B      = 1'b0;
        SLOT_BUSRQ_B = 4'b1110;
        z80_en       = 1'b1;
        ack_delay    = 0;
        tick(2);
        n_checks++;
        if ({BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR} !== 8'b1_1111_00_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b%b, need 1111100 0",
                     BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR);
        end
        RESET_B = 1'b1;
        tick(2);
        n_checks++;
        if (BUSRQ_B !== 1'b1) begin
            n_fail++;
            $display("FAIL busrq_early: got %b after 2 cycles, need 1", BUSRQ_B);
        end
        tick(1);
        n_checks++;
        if (BUSRQ_B !== 1'b0) begin
            n_fail++;
            $display("FAIL busrq_latency: got %b after 3 cycles, need 0", BUSRQ_B);
        end
        tick(1);
        n_checks++;
        if (SLOT_BUSACK_B !== 4'b1111) begin
            n_fail++;
            $display("FAIL ack_early: got %b, need 1111", SLOT_BUSACK_B);
        end
        tick(1);
        n_checks++;
        if (SLOT_BUSACK_B !== 4'b1110 || GRANT_ID !== 2'd0) begin
            n_fail++;
            $display("FAIL first_grant: ack %b id %0d, need 1110 id 0",
                     SLOT_BUSACK_B, GRANT_ID);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        bit saw;
        logic [NS-1:0] exp_ack;
        apply_reset(4'b0000);
        for (int k = 0; k < 5; k++) begin
            wait_ack(1'b1, ok, saw);
            exp_ack = 4'b0001 << (k % NS);
            exp_ack = ~exp_ack;
            n_checks++;
            if (!ok || SLOT_BUSACK_B !== exp_ack || GRANT_ID !== 2'(k % NS)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ack %b id %0d ok %0d, need %b id %0d",
                         k, SLOT_BUSACK_B, GRANT_ID, ok, exp_ack, k % NS);
            end
            if (k > 0) begin
                n_checks++;
                if (!saw) begin
                    n_fail++;
                    $display("FAIL rr_release%0d: busack high seen %0d, need 1",
                             k, saw);
                end
            end
            wait_ack(1'b0, ok, saw);
        end
        n_checks++;
        if (HOLD_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_hold_err: got %b, need 1", HOLD_ERR);
        end
    endtask

    task automatic test_withdraw();
        bit bad;
        apply_reset(4'b1111);
        z80_en = 1'b0;
        man_ack_b = 1'b1;
        SLOT_BUSRQ_B = 4'b1011;
        tick(3);
        n_checks++;
        if (BUSRQ_B !== 1'b0 || GRANT_ID !== 2'd2) begin
            n_fail++;
            $display("FAIL wd_request: busrq %b id %0d, need 0 id 2",
                     BUSRQ_B, GRANT_ID);
        end
        SLOT_BUSRQ_B = 4'b1111;
        tick(2);
        man_ack_b = 1'b0;
        tick(1);
        n_checks++;
        if (BUSRQ_B !== 1'b1 || SLOT_BUSACK_B !== 4'b1111) begin
            n_fail++;
            $display("FAIL wd_drop: busrq %b ack %b, need 1 1111",
                     BUSRQ_B, SLOT_BUSACK_B);
        end
        SLOT_BUSRQ_B = 4'b0110;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (BUSRQ_B !== 1'b1 || SLOT_BUSACK_B !== 4'b1111) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL wd_release_wait: busrq/ack moved while busack low, need 1/1111");
        end
        man_ack_b = 1'b1;
        tick(1);
        n_checks++;
        if (BUSRQ_B !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_idle_step: busrq %b, need 1", BUSRQ_B);
        end
        tick(1);
        n_checks++;
        if (BUSRQ_B !== 1'b0 || GRANT_ID !== 2'd0) begin
            n_fail++;
            $display("FAIL wd_pointer: busrq %b id %0d, need 0 id 0",
                     BUSRQ_B, GRANT_ID);
        end
        z80_en = 1'b1;
    endtask

    task automatic test_hold_limit();
        bit ok;
        bit saw;
        int len;
        logic [NS-1:0] exp_ack;
        logic [1:0] order [3];
        order[0] = 2'd3;
        order[1] = 2'd0;
        order[2] = 2'd1;
        apply_reset(4'b1111);
        SLOT_BUSRQ_B = 4'b1101;
        wait_ack(1'b1, ok, saw);
        n_checks++;
        if (!ok || SLOT_BUSACK_B !== 4'b1101 || GRANT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL hl_grant: ack %b id %0d, need 1101 id 1",
                     SLOT_BUSACK_B, GRANT_ID);
        end
        SLOT_BUSRQ_B = 4'b0100;
        len = 0;
        while (SLOT_BUSACK_B == 4'b1101 && len < 20) begin
            len++;
            tick(1);
        end
        n_checks++;
        if (len != HL) begin
            n_fail++;
            $display("FAIL hl_length: ack low %0d cycles, need %0d", len, HL);
        end
        n_checks++;
        if (BUSRQ_B !== 1'b1 || SLOT_BUSACK_B !== 4'b1111 || HOLD_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL hl_revoke: busrq %b ack %b err %b, need 1 1111 1",
                     BUSRQ_B, SLOT_BUSACK_B, HOLD_ERR);
        end
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, ok, saw);
            exp_ack = 4'b0001 << order[k];
            exp_ack = ~exp_ack;
            n_checks++;
            if (!ok || SLOT_BUSACK_B !== exp_ack || GRANT_ID !== order[k]) begin
                n_fail++;
                $display("FAIL hl_order%0d: ack %b id %0d, need %b id %0d",
                         k, SLOT_BUSACK_B, GRANT_ID, exp_ack, order[k]);
            end
            wait_ack(1'b0, ok, saw);
        end
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        bit saw;
        apply_reset(4'b1011);
        wait_ack(1'b1, ok, saw);
        wait_ack(1'b0, ok, saw);
        wait_ack(1'b1, ok, saw);
        n_checks++;
        if (!ok || SLOT_BUSACK_B !== 4'b1011 || HOLD_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_regrant: ack %b err %b, need 1011 1",
                     SLOT_BUSACK_B, HOLD_ERR);
        end
        tick(2);
        #2;
        RESET_B = 1'b0;
        #1;
        n_checks++;
        if ({BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR} !== 8'b1_1111_00_0) begin
            n_fail++;
            $display("FAIL mr_async: got %b%b%b%b, need 1111100 0",
                     BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR);
        end
        SLOT_BUSRQ_B = 4'b1010;
        tick(2);
        RESET_B = 1'b1;
        wait_ack(1'b1, ok, saw);
        n_checks++;
        if (!ok || SLOT_BUSACK_B !== 4'b1110 || GRANT_ID !== 2'd0) begin
            n_fail++;
            $display("FAIL mr_first: ack %b id %0d, need 1110 id 0",
                     SLOT_BUSACK_B, GRANT_ID);
        end
    endtask

    task automatic test_spurious_ack();
        bit bad;
        apply_reset(4'b1111);
        z80_en = 1'b0;
        man_ack_b = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if ({BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR} !== 8'b1_1111_00_0)
                bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL spurious_ack: got %b%b%b%b, need 1111100 0",
                     BUSRQ_B, SLOT_BUSACK_B, GRANT_ID, HOLD_ERR);
        end
        man_ack_b = 1'b1;
        z80_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_withdraw();
        test_hold_limit();
        test_reset_mid_grant();
        test_spurious_ack();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
